// File: rtl/writeback_delay.sv
// writeback_delay: parks execute-stage results for a per-entry commit delay, then writes them to the ROB one per cycle.
// Optional feature: define WRITEBACK_BYPASS_EN so zero-delay results skip the slot array when no slot is ready.
module writeback_delay #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_flush,
  input  logic              i_valid,
  input  logic [3:0]        i_dst_rob,
  input  logic [7:0]        i_fid,
  input  logic [DATA_W-1:0] i_result,
  input  logic [3:0]        i_cmtdelay,
  input  logic              i_lsmiss,
  output logic              o_readyn,
  output logic              o_overflow,
  output logic              o_rob_wen,
  output logic [3:0]        o_rob_addr,
  output logic [7:0]        o_rob_fid,
  output logic [DATA_W-1:0] o_rob_value,
  output logic              o_rob_lsmiss
);

  localparam int IDX_W = $clog2(DEPTH);

  function automatic logic [IDX_W-1:0] lowest_set(input logic [DEPTH-1:0] vec);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  function automatic logic [3:0] count_set(input logic [DEPTH-1:0] vec);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < DEPTH; i++) begin
      n = n + {3'b000, vec[i]};
    end
    return n;
  endfunction

  logic              slot_vld_p0 [DEPTH];
  logic [3:0]        slot_cnt_p0 [DEPTH];
  logic [3:0]        slot_rob_p0 [DEPTH];
  logic [7:0]        slot_fid_p0 [DEPTH];
  logic [DATA_W-1:0] slot_res_p0 [DEPTH];
  logic              slot_ls_p0  [DEPTH];

  logic [DEPTH-1:0]  elig;
  logic [DEPTH-1:0]  free_vec;
  logic [IDX_W-1:0]  sel_idx;
  logic [IDX_W-1:0]  alloc_idx;
  logic              any_elig;
  logic              any_free;
  logic              bypass;
  logic              capture;
  logic              drop;

  // Selection: lowest eligible slot writes back; that slot counts as free for this edge's capture.
  always_comb begin
    elig     = '0;
    free_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      elig[i] = slot_vld_p0[i] && (slot_cnt_p0[i] == 4'd0);
    end
    any_elig = |elig;
    sel_idx  = lowest_set(elig);
    for (int i = 0; i < DEPTH; i++) begin
      free_vec[i] = !slot_vld_p0[i] || (any_elig && (sel_idx == IDX_W'(i)));
    end
    any_free  = |free_vec;
    alloc_idx = lowest_set(free_vec);
  end

`ifdef WRITEBACK_BYPASS_EN
  assign bypass = i_valid && !i_flush && (i_cmtdelay == 4'd0) && !any_elig;
`else
  assign bypass = 1'b0;
`endif

  assign capture  = i_valid && !i_flush && !bypass && any_free;
  assign drop     = i_valid && !i_flush && !bypass && !any_free;
  assign o_readyn = count_set(free_vec) < 4'd2;

  // Control state and ROB write port
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        slot_vld_p0[i] <= 1'b0;
        slot_cnt_p0[i] <= 4'd0;
      end
      o_overflow   <= 1'b0;
      o_rob_wen    <= 1'b0;
      o_rob_addr   <= '0;
      o_rob_fid    <= '0;
      o_rob_value  <= '0;
      o_rob_lsmiss <= 1'b0;
    end else begin
      o_overflow <= drop;
      for (int i = 0; i < DEPTH; i++) begin
        if (i_flush) begin
          slot_vld_p0[i] <= 1'b0;
        end else if (capture && (alloc_idx == IDX_W'(i))) begin
          slot_vld_p0[i] <= 1'b1;
          slot_cnt_p0[i] <= i_cmtdelay;
        end else begin
          if (any_elig && (sel_idx == IDX_W'(i))) slot_vld_p0[i] <= 1'b0;
          if (slot_cnt_p0[i] != 4'd0) slot_cnt_p0[i] <= slot_cnt_p0[i] - 4'd1;
        end
      end
      if (i_flush) begin
        o_rob_wen <= 1'b0;
      end else if (any_elig) begin
        o_rob_wen    <= 1'b1;
        o_rob_addr   <= slot_rob_p0[sel_idx];
        o_rob_fid    <= slot_fid_p0[sel_idx];
        o_rob_value  <= slot_res_p0[sel_idx];
        o_rob_lsmiss <= slot_ls_p0[sel_idx];
      end else if (bypass) begin
        o_rob_wen    <= 1'b1;
        o_rob_addr   <= i_dst_rob;
        o_rob_fid    <= i_fid;
        o_rob_value  <= i_result;
        o_rob_lsmiss <= i_lsmiss;
      end else begin
        o_rob_wen <= 1'b0;
      end
    end
  end

  // Slot payload is only meaningful while its valid bit is set, so it carries no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (capture && (alloc_idx == IDX_W'(i))) begin
        slot_rob_p0[i] <= i_dst_rob;
        slot_fid_p0[i] <= i_fid;
        slot_res_p0[i] <= i_result;
        slot_ls_p0[i]  <= i_lsmiss;
      end
    end
  end

endmodule

// File: tb/tb_writeback_delay.sv
// Bench for writeback_delay: table of single-result latencies plus hand sequences, ROB writes checked by a scoreboard queue.
`timescale 1ns/1ps
module tb_writeback_delay;

`ifdef WRITEBACK_BYPASS_EN
  localparam int LAT0 = 0;
`else
  localparam int LAT0 = 1;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        i_flush = 1'b0;
  logic        i_valid = 1'b0;
  logic [3:0]  i_dst_rob = '0;
  logic [7:0]  i_fid = '0;
  logic [31:0] i_result = '0;
  logic [3:0]  i_cmtdelay = '0;
  logic        i_lsmiss = 1'b0;
  logic        o_readyn, o_overflow, o_rob_wen, o_rob_lsmiss;
  logic [3:0]  o_rob_addr;
  logic [7:0]  o_rob_fid;
  logic [31:0] o_rob_value;

  always #5 clk = ~clk;

  writeback_delay #(.DEPTH(4), .DATA_W(32)) dut (
    .clk(clk), .resetn(resetn), .i_flush(i_flush), .i_valid(i_valid),
    .i_dst_rob(i_dst_rob), .i_fid(i_fid), .i_result(i_result),
    .i_cmtdelay(i_cmtdelay), .i_lsmiss(i_lsmiss), .o_readyn(o_readyn),
    .o_overflow(o_overflow), .o_rob_wen(o_rob_wen), .o_rob_addr(o_rob_addr),
    .o_rob_fid(o_rob_fid), .o_rob_value(o_rob_value), .o_rob_lsmiss(o_rob_lsmiss)
  );

  typedef struct packed {
    logic [3:0]  rob;
    logic [7:0]  fid;
    logic [31:0] res;
    logic        ls;
  } wr_t;

  typedef struct packed {
    logic [3:0]  rob;
    logic [7:0]  fid;
    logic [31:0] res;
    logic [3:0]  d;
    logic        ls;
    logic [4:0]  lat;
  } vec_t;

  vec_t vecs [6];
  wr_t  exp_q [$];
  int   wr_cycles [$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   n_writes = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock and score any ROB write against the queue.
  task automatic tick();
    wr_t got;
    wr_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (o_rob_wen === 1'b1) begin
      n_writes++;
      wr_cycles.push_back(cyc);
      check("write_expected", 64'(o_rob_wen), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        got = {o_rob_addr, o_rob_fid, o_rob_value, o_rob_lsmiss};
        e = exp_q.pop_front();
        check("rob_write", 64'(got), 64'(e));
      end
    end
  endtask

  function automatic vec_t mk(input logic [3:0] rob, input logic [7:0] fid,
                              input logic [31:0] res, input logic [3:0] d, input logic ls);
    return {rob, fid, res, d, ls, 5'd0};
  endfunction

  task automatic drive(input vec_t v, input bit track);
    i_valid    = 1'b1;
    i_dst_rob  = v.rob;
    i_fid      = v.fid;
    i_result   = v.res;
    i_cmtdelay = v.d;
    i_lsmiss   = v.ls;
    if (track) exp_q.push_back({v.rob, v.fid, v.res, v.ls});
  endtask

  task automatic idle();
    i_valid = 1'b0;
  endtask

  task automatic wait_writes(input int target, input int budget, input string name);
    for (int k = 0; k < budget && n_writes < target; k++) tick();
    check(name, 64'(n_writes), 64'(target));
  endtask

  initial begin
    int nb;
    int c0;
    vecs[0] = {4'd3,  8'h01, 32'hDEADBEEF, 4'd0,  1'b0, 5'(LAT0)};
    vecs[1] = {4'd7,  8'h02, 32'h12345678, 4'd5,  1'b1, 5'd6};
    vecs[2] = {4'd0,  8'hFF, 32'h00000000, 4'd1,  1'b0, 5'd2};
    vecs[3] = {4'd15, 8'h80, 32'hFFFFFFFF, 4'd15, 1'b1, 5'd16};
    vecs[4] = {4'd9,  8'h5A, 32'hA5A5A5A5, 4'd2,  1'b1, 5'd3};
    vecs[5] = {4'd1,  8'h33, 32'h00000001, 4'd0,  1'b1, 5'(LAT0)};

    // Reset state, with stray inputs that must be ignored
    i_valid = 1'b1;
    i_flush = 1'b1;
    repeat (3) tick();
    check("rst_wen", 64'(o_rob_wen), 64'd0);
    check("rst_ovf", 64'(o_overflow), 64'd0);
    check("rst_readyn", 64'(o_readyn), 64'd0);
    check("rst_addr", 64'(o_rob_addr), 64'd0);
    check("rst_fid", 64'(o_rob_fid), 64'd0);
    check("rst_value", 64'(o_rob_value), 64'd0);
    i_valid = 1'b0;
    i_flush = 1'b0;
    resetn = 1'b1;
    tick();

    // Single results, uncontended latency
    for (int v = 0; v < 6; v++) begin
      nb = n_writes;
      drive(vecs[v], 1'b1);
      tick();
      c0 = cyc;
      idle();
      for (int k = 0; k < 40 && n_writes == nb; k++) tick();
      check($sformatf("vec%0d_write", v), 64'(n_writes), 64'(nb + 1));
      check($sformatf("vec%0d_latency", v), 64'(wr_cycles[nb] - c0), 64'(vecs[v].lat));
      repeat (2) tick();
    end

    // Back-to-back zero-delay results: consecutive writes
    nb = n_writes;
    drive(mk(4'd2, 8'hA0, 32'h0000AAAA, 4'd0, 1'b0), 1'b1);
    tick();
    drive(mk(4'd6, 8'hA1, 32'h0000BBBB, 4'd0, 1'b1), 1'b1);
    tick();
    idle();
    wait_writes(nb + 2, 10, "b2b_writes");
    check("b2b_gap", 64'(wr_cycles[nb + 1] - wr_cycles[nb]), 64'd1);
    repeat (2) tick();

    // Fill all four slots, then overflow
    nb = n_writes;
    c0 = 0;
    for (int k = 0; k < 4; k++) begin
      drive(mk(4'(k + 4), 8'(k + 8'h40), 32'(k + 32'h1000), 4'd15, 1'(k)), 1'b1);
      tick();
      if (k == 0) c0 = cyc;
      check($sformatf("fill%0d_readyn", k), 64'(o_readyn), 64'(k >= 2));
      check($sformatf("fill%0d_ovf", k), 64'(o_overflow), 64'd0);
    end
    drive(mk(4'd12, 8'hEE, 32'hBAD0BAD0, 4'd15, 1'b0), 1'b0);
    tick();
    check("ovf_pulse", 64'(o_overflow), 64'd1);
    idle();
    tick();
    check("ovf_clear", 64'(o_overflow), 64'd0);
    wait_writes(nb + 4, 30, "ovf_writes");
    check("ovf_first_lat", 64'(wr_cycles[nb] - c0), 64'd16);
    check("ovf_span", 64'(wr_cycles[nb + 3] - wr_cycles[nb]), 64'd3);
    repeat (2) tick();

    // Flush with three pending and a simultaneous input
    nb = n_writes;
    for (int k = 0; k < 3; k++) begin
      drive(mk(4'(k + 10), 8'(k + 8'h60), 32'(k + 32'h6000), 4'd10, 1'b0), 1'b0);
      tick();
    end
    drive(mk(4'd13, 8'h6F, 32'h66666666, 4'd0, 1'b1), 1'b0);
    i_flush = 1'b1;
    tick();
    check("flush_ovf", 64'(o_overflow), 64'd0);
    check("flush_wen", 64'(o_rob_wen), 64'd0);
    check("flush_readyn", 64'(o_readyn), 64'd0);
    i_flush = 1'b0;
    idle();
    repeat (20) tick();
    check("flush_no_writes", 64'(n_writes), 64'(nb));

    // Reset during countdown while a write is on the port
    nb = n_writes;
    drive(mk(4'd5, 8'h77, 32'hCAFEF00D, 4'd1, 1'b1), 1'b1);
    tick();
    drive(mk(4'd8, 8'h78, 32'h0BADCAFE, 4'd8, 1'b0), 1'b0);
    tick();
    idle();
    tick();
    check("rst_pre_write", 64'(n_writes), 64'(nb + 1));
    resetn = 1'b0;
    #1;
    check("rst_mid_wen", 64'(o_rob_wen), 64'd0);
    check("rst_mid_addr", 64'(o_rob_addr), 64'd0);
    check("rst_mid_value", 64'(o_rob_value), 64'd0);
    check("rst_mid_lsmiss", 64'(o_rob_lsmiss), 64'd0);
    check("rst_mid_readyn", 64'(o_readyn), 64'd0);
    repeat (2) tick();
    resetn = 1'b1;
    nb = n_writes;
    repeat (15) tick();
    check("post_rst_quiet", 64'(n_writes), 64'(nb));
    drive(mk(4'd11, 8'h99, 32'h13579BDF, 4'd2, 1'b0), 1'b1);
    tick();
    c0 = cyc;
    idle();
    wait_writes(nb + 1, 10, "post_rst_write");
    check("post_rst_latency", 64'(wr_cycles[nb] - c0), 64'd3);

    repeat (3) tick();
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/writeback_delay.md
WRITEBACK_DELAY -- requirements
Module: writeback_delay

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of pending-result slots (2..8).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port i_flush  input  1  synchronous clear of all pending results (pipeline flush).
REQ-005 SHALL have port i_valid  input  1  execute-stage result valid.
REQ-006 SHALL have port i_dst_rob  input  4  destination ROB index.
REQ-007 SHALL have port i_fid  input  8  fetch id.
REQ-008 SHALL have port i_result  input  32  result value.
REQ-009 SHALL have port i_cmtdelay  input  4  extra cycles to hold before ROB write.
REQ-010 SHALL have port i_lsmiss  input  1  load/store miss flag.
REQ-011 SHALL have port o_readyn  output  1  high = issue must not send a new op next cycle.
REQ-012 SHALL have port o_overflow  output  1  one-cycle pulse: a valid input was dropped.
REQ-013 SHALL have port o_rob_wen  output  1  ROB write enable (registered).
REQ-014 SHALL have ports o_rob_addr (4), o_rob_fid (8), o_rob_value (32), o_rob_lsmiss (1), all outputs, registered, the written entry's fields.

Function
REQ-015 SHALL hold DEPTH slots, each: valid, rob, fid, result, lsmiss, cnt[3:0].
REQ-016 SHALL capture i_valid at an edge into the lowest-index free slot, cnt = i_cmtdelay.
REQ-017 SHALL decrement each valid slot's cnt by 1 per edge while cnt != 0; cnt never wraps below 0.
REQ-018 SHALL deem a slot eligible when valid and cnt == 0 (as registered before the edge).
REQ-019 SHALL, at each edge, load the output registers from the lowest-index eligible slot, set o_rob_wen=1, and free that slot; with no eligible slot, o_rob_wen=0 and data outputs hold.
REQ-020 SHALL let non-selected eligible slots wait with cnt == 0; one ROB write per cycle maximum.
REQ-021 SHALL give latency: input sampled at edge E0 with cmtdelay d -> o_rob_wen high in the cycle after edge E(d+1) when uncontended.
REQ-022 SHALL allow a slot freed at an edge to be reused by a capture at that same edge.
REQ-023 SHALL drive o_readyn combinationally high when free slots (after this cycle's selection) < 2.
REQ-024 SHALL, when i_valid is high and no slot is free after selection, drop the input and pulse o_overflow for one cycle; existing slots are unaffected.
REQ-025 SHALL, on i_flush, clear all slot valid bits and o_rob_wen at that edge; simultaneous i_valid is discarded with no o_overflow.

Reset
REQ-026 SHALL, on resetn low, immediately clear all slot valid bits and cnt, o_rob_wen=0, o_overflow=0, o_rob_addr/fid/value/lsmiss=0.
REQ-027 SHALL, with resetn low, ignore i_valid and i_flush; o_readyn=0 after reset (all slots free).
REQ-028 SHALL resume capture on the first rising edge after resetn deasserts.

Configuration
REQ-029 SHALL, with WRITEBACK_BYPASS_EN defined, route an input with i_cmtdelay == 0 directly into the output registers at E0 (o_rob_wen the next cycle) when no slot is eligible, without allocating a slot.
REQ-030 SHALL, without WRITEBACK_BYPASS_EN, always allocate a slot (REQ-016), giving a minimum of 2 cycles from input to ROB write.
REQ-031 SHALL, with bypass enabled and an eligible slot present, give the slot priority and allocate the input normally.

Verification
REQ-032 SHALL cover: i_valid, rob=3, cmtdelay=0, result=0xDEADBEEF -> o_rob_wen, addr=3, value 0xDEADBEEF two cycles later (one with WRITEBACK_BYPASS_EN).
REQ-033 SHALL cover: cmtdelay=5, rob=7 -> o_rob_wen, addr=7 exactly 6 cycles after the sample edge.
REQ-034 SHALL cover: two back-to-back inputs, both cmtdelay=0 -> two consecutive ROB writes in slot order, no gap.
REQ-035 SHALL cover: DEPTH=4, four inputs with cmtdelay=15 -> o_readyn high after the third; the fifth input -> o_overflow pulse, dropped, four writes follow.
REQ-036 SHALL cover: i_flush with 3 pending slots and i_valid high -> no ROB writes afterwards, o_overflow stays 0.
REQ-037 SHALL cover: resetn asserted low mid-countdown -> o_rob_wen=0 immediately; no writes after release until new input.
